// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Generic pipeline stage register for an in-order CPU pipeline. It carries
// one instruction slot: its instruction word, PC, NCH packed data channels,
// an opaque control bundle, the register numbers and the Tnew hazard
// counter. The stage can load, hold (stall) or be loaded with a bubble
// (flush). It also keeps a saturating count of bubbles loaded since reset.
//
// Parameters
//   DW               width of Instr, PC and each data channel
//   NCH              number of DW-bit data channels
//   CW               width of the opaque control bundle
//   AW               register-address width
//   TW               Tnew width
//   KEEP_PC_ON_FLUSH 1 = a flush loads PC_i into PC_o, 0 = a flush clears PC_o
//   DEC_ON_HOLD      1 = a held Tnew keeps counting down, 0 = it is frozen
//
// Ports
//   clk, reset            clock and synchronous active-high reset
//   stall, flush          hold contents / load a bubble (flush wins)
//   RegWrite_i/_o         GRF write enable
//   Ctrl_i/_o             control bundle
//   Instr_i/_o, PC_i/_o   instruction word and address
//   Data_i/_o             packed channels, channel k at [k*DW +: DW]
//   A1/A2/A3_i/_o         source and destination register numbers
//   Tnew_i/_o             cycles until the result is available
//   Valid_o               1 = real instruction, 0 = bubble
//   Bubbles_o             saturating count of bubbles loaded since reset
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
   parameter int DW               = 32,
   parameter int NCH              = 2,
   parameter int CW               = 6,
   parameter int AW               = 5,
   parameter int TW               = 3,
   parameter int KEEP_PC_ON_FLUSH = 1,
   parameter int DEC_ON_HOLD      = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              RegWrite_i,
   input  logic [CW-1:0]     Ctrl_i,
   input  logic [DW-1:0]     Instr_i,
   input  logic [DW-1:0]     PC_i,
   input  logic [NCH*DW-1:0] Data_i,
   input  logic [AW-1:0]     A1_i,
   input  logic [AW-1:0]     A2_i,
   input  logic [AW-1:0]     A3_i,
   input  logic [TW-1:0]     Tnew_i,
   output logic              RegWrite_o,
   output logic [CW-1:0]     Ctrl_o,
   output logic [DW-1:0]     Instr_o,
   output logic [DW-1:0]     PC_o,
   output logic [NCH*DW-1:0] Data_o,
   output logic [AW-1:0]     A1_o,
   output logic [AW-1:0]     A2_o,
   output logic [AW-1:0]     A3_o,
   output logic [TW-1:0]     Tnew_o,
   output logic              Valid_o,
   output logic [15:0]       Bubbles_o
);

   // Countdown that stops at zero instead of wrapping.
   function automatic logic [TW-1:0] tnew_dec(input logic [TW-1:0] t);
      return (t == '0) ? '0 : t - TW'(1);
   endfunction

   // Bubble counter increment that sticks at all-ones.
   function automatic logic [15:0] bub_inc(input logic [15:0] b);
      return (b == 16'hFFFF) ? b : b + 16'd1;
   endfunction

   // Initialisers give the post-reset values from power-up onward.
   logic              regwrite_q = 1'b0;
   logic [CW-1:0]     ctrl_q     = '0;
   logic [DW-1:0]     instr_q    = '0;
   logic [DW-1:0]     pc_q       = '0;
   logic [NCH*DW-1:0] data_q     = '0;
   logic [AW-1:0]     a1_q       = '0;
   logic [AW-1:0]     a2_q       = '0;
   logic [AW-1:0]     a3_q       = '0;
   logic [TW-1:0]     tnew_q     = '0;
   logic              valid_q    = 1'b0;
   logic [15:0]       bubbles_q  = '0;

   logic              regwrite_d;
   logic [CW-1:0]     ctrl_d;
   logic [DW-1:0]     instr_d;
   logic [DW-1:0]     pc_d;
   logic [NCH*DW-1:0] data_d;
   logic [AW-1:0]     a1_d;
   logic [AW-1:0]     a2_d;
   logic [AW-1:0]     a3_d;
   logic [TW-1:0]     tnew_d;
   logic              valid_d;
   logic [15:0]       bubbles_d;

   // Next-state selection: flush > stall > load (reset handled in the register).
   always_comb begin
      regwrite_d = regwrite_q;
      ctrl_d     = ctrl_q;
      instr_d    = instr_q;
      pc_d       = pc_q;
      data_d     = data_q;
      a1_d       = a1_q;
      a2_d       = a2_q;
      a3_d       = a3_q;
      tnew_d     = tnew_q;
      valid_d    = valid_q;
      bubbles_d  = bubbles_q;

      if (flush) begin
         regwrite_d = 1'b0;
         ctrl_d     = '0;
         instr_d    = '0;
         pc_d       = (KEEP_PC_ON_FLUSH != 0) ? PC_i : '0;
         data_d     = '0;
         a1_d       = '0;
         a2_d       = '0;
         a3_d       = '0;
         tnew_d     = '0;
         valid_d    = 1'b0;
         bubbles_d  = bub_inc(bubbles_q);
      end else if (!stall) begin
         // A write to register 0 is architecturally void: it must neither
         // write the GRF nor look like a pending producer to hazard logic.
         regwrite_d = RegWrite_i && (A3_i != '0);
         ctrl_d     = Ctrl_i;
         instr_d    = Instr_i;
         pc_d       = PC_i;
         data_d     = Data_i;
         a1_d       = A1_i;
         a2_d       = A2_i;
         a3_d       = A3_i;
         tnew_d     = (A3_i == '0) ? '0 : tnew_dec(Tnew_i);
         valid_d    = 1'b1;
      end else if (DEC_ON_HOLD != 0) begin
         tnew_d     = tnew_dec(tnew_q);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         regwrite_q <= 1'b0;
         ctrl_q     <= '0;
         instr_q    <= '0;
         pc_q       <= '0;
         data_q     <= '0;
         a1_q       <= '0;
         a2_q       <= '0;
         a3_q       <= '0;
         tnew_q     <= '0;
         valid_q    <= 1'b0;
         bubbles_q  <= '0;
      end else begin
         regwrite_q <= regwrite_d;
         ctrl_q     <= ctrl_d;
         instr_q    <= instr_d;
         pc_q       <= pc_d;
         data_q     <= data_d;
         a1_q       <= a1_d;
         a2_q       <= a2_d;
         a3_q       <= a3_d;
         tnew_q     <= tnew_d;
         valid_q    <= valid_d;
         bubbles_q  <= bubbles_d;
      end
   end

   assign RegWrite_o = regwrite_q;
   assign Ctrl_o     = ctrl_q;
   assign Instr_o    = instr_q;
   assign PC_o       = pc_q;
   assign Data_o     = data_q;
   assign A1_o       = a1_q;
   assign A2_o       = a2_q;
   assign A3_o       = a3_q;
   assign Tnew_o     = tnew_q;
   assign Valid_o    = valid_q;
   assign Bubbles_o  = bubbles_q;

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DW, 32, width of Instr, PC and each data channel.
- NCH, 2, number of DW-bit data channels (e.g. ALU result, store data).
- CW, 6, width of opaque control bundle (MemWrite, level selects, ...).
- AW, 5, register-address width.
- TW, 3, Tnew width.
- KEEP_PC_ON_FLUSH, 1, 1 = flush loads PC_i into PC_o; 0 = flush clears PC_o.
- DEC_ON_HOLD, 0, 1 = held Tnew still counts down; 0 = held Tnew frozen.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on rising edge.
- reset, in, 1, synchronous, active-high.
- stall, in, 1, hold current contents.
- flush, in, 1, load a bubble.
- RegWrite_i / RegWrite_o, in/out, 1, GRF write enable.
- Ctrl_i / Ctrl_o, in/out, CW, control bundle.
- Instr_i / Instr_o, in/out, DW, instruction word.
- PC_i / PC_o, in/out, DW, instruction address.
- Data_i / Data_o, in/out, NCH*DW, packed channels; channel k at bits [k*DW +: DW].
- A1_i, A2_i, A3_i / A1_o, A2_o, A3_o, in/out, AW each, source and destination register numbers.
- Tnew_i / Tnew_o, in/out, TW, cycles until result available.
- Valid_o, out, 1, 1 = slot holds a real instruction, 0 = bubble.
- Bubbles_o, out, 16, saturating count of bubbles loaded since reset.

Function
REQ-003 Priority per rising edge: reset > flush > stall > load; exactly one applies.
REQ-004 Load (no reset, flush or stall): every _o register takes its _i value, Valid_o=1, with REQ-007 and REQ-008 applied; latency one cycle.
REQ-005 Stall: all _o registers hold, except Tnew_o, which decrements per REQ-008 when DEC_ON_HOLD=1.
REQ-006 Flush: RegWrite_o=0, Ctrl_o=0, Instr_o=0, Data_o=0, A1_o=A2_o=A3_o=0, Tnew_o=0, Valid_o=0; PC_o=PC_i if KEEP_PC_ON_FLUSH=1, else 0; Bubbles_o increments.
REQ-007 Load with A3_i==0: RegWrite_o=0 and Tnew_o=0 regardless of inputs; all other fields load normally.
REQ-008 Tnew countdown: Tnew_o = Tnew_i-1 when Tnew_i>=1, else 0; never wraps. When DEC_ON_HOLD=1, a held Tnew_o becomes Tnew_o-1, saturating at 0.
REQ-009 Stall and flush in the same cycle: flush wins (REQ-003); the bubble is loaded.
REQ-010 Bubbles_o saturates at 16'hFFFF and holds there; it changes only on flush and reset.
REQ-011 Outputs are driven directly from registers; there is no combinational path from any input to any output.
REQ-012 Behaviour is identical for every legal NCH>=1 and DW>=1; channels are independent, with no cross-channel mixing.

Reset
REQ-013 While reset=1 at an edge: all _o fields, Valid_o and Bubbles_o become 0, including PC_o regardless of KEEP_PC_ON_FLUSH; stall and flush are ignored.
REQ-014 Power-up: all registers initialise to the REQ-013 values before the first edge.
REQ-015 Reset asserted while stalled: contents are still cleared at the next edge; the held instruction is lost.

Verification
REQ-016 Load: A3_i=8, RegWrite_i=1, Tnew_i=2, Data_i={32'h1234,32'hABCD}, PC_i=32'h3000 -> next cycle A3_o=8, RegWrite_o=1, Tnew_o=1, Data_o channel0=32'hABCD, channel1=32'h1234, PC_o=32'h3000, Valid_o=1.
REQ-017 Saturation: Tnew_i=0 -> Tnew_o=0. With DEC_ON_HOLD=1, load Tnew_i=3 (Tnew_o=2), then stall 3 cycles -> Tnew_o=1, 0, 0.
REQ-018 Flush: PC_i=32'h3004, flush=1, stall=1 -> Valid_o=0, A3_o=0, Tnew_o=0, PC_o=32'h3004 (KEEP_PC_ON_FLUSH=1), Bubbles_o incremented by 1.
REQ-019 $0 write: A3_i=0, RegWrite_i=1, Tnew_i=2 -> RegWrite_o=0, Tnew_o=0, Valid_o=1.
REQ-020 Reset: after 5 flushes, reset=1 with stall=1 -> next cycle all outputs 0, Bubbles_o=0; with Bubbles_o forced to 16'hFFFF, one more flush -> Bubbles_o stays 16'hFFFF.
